router_pkt_gen: RTL and testbench

Self-test traffic source that drives the router's input port: header, payload, parity, using the router's pkt_valid/busy protocol. Header carries the destination in bits [1:0] and the payload length in bits [7:2]. Payload bytes come from an internal LFSR, and the final parity byte is the XOR of all preceding bytes. Sits in front of the router input for BIST and bring-up; also counts packets sent and error reports returned by the router.

---
 rtl/router_pkt_gen.sv | 200 ++++++++++++++++++++
 tb/tb_router_pkt_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_gen.sv
// rtl/router_pkt_gen.sv - Router self-test packet source (header, LFSR payload, parity); optional ERR_INJECT_EN adds inj_err
module router_pkt_gen #(
    parameter int IPG = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] seed,
    input  logic       busy,
    input  logic       err,
`ifdef ERR_INJECT_EN
    input  logic       inj_err,
`endif
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       idle,
    output logic       done,
    output logic       bad_req,
    output logic [7:0] pkt_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Gap counter is loaded with IPG-1 so GAP lasts exactly IPG cycles
    localparam logic [3:0] GAP_LOAD = (IPG > 0) ? 4'(IPG - 1) : 4'd0;

    state_t     state, state_nxt;
    logic [1:0] dest_q, dest_nxt;
    logic [5:0] len_q, len_nxt;
    logic [7:0] lfsr, lfsr_nxt;
    logic [7:0] parity_acc, parity_nxt;
    logic [5:0] remaining, remaining_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic       inj_q, inj_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       idle_nxt;
    logic       done_nxt;
    logic       bad_nxt;
    logic [7:0] pkt_cnt_nxt;
    logic       err_q;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // State and registered outputs; reset aborts any packet in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            dest_q     <= 2'd0;
            len_q      <= 6'd0;
            lfsr       <= 8'd0;
            parity_acc <= 8'd0;
            remaining  <= 6'd0;
            gap_cnt    <= 4'd0;
            inj_q      <= 1'b0;
            data_out   <= 8'd0;
            pkt_valid  <= 1'b0;
            idle       <= 1'b1;
            done       <= 1'b0;
            bad_req    <= 1'b0;
            pkt_cnt    <= 8'd0;
        end else begin
            state      <= state_nxt;
            dest_q     <= dest_nxt;
            len_q      <= len_nxt;
            lfsr       <= lfsr_nxt;
            parity_acc <= parity_nxt;
            remaining  <= remaining_nxt;
            gap_cnt    <= gap_nxt;
            inj_q      <= inj_nxt;
            data_out   <= data_nxt;
            pkt_valid  <= valid_nxt;
            idle       <= idle_nxt;
            done       <= done_nxt;
            bad_req    <= bad_nxt;
            pkt_cnt    <= pkt_cnt_nxt;
        end
    end

    // Next-state and next-output logic; busy freezes everything in transmit states
    always_comb begin
        state_nxt     = state;
        dest_nxt      = dest_q;
        len_nxt       = len_q;
        lfsr_nxt      = lfsr;
        parity_nxt    = parity_acc;
        remaining_nxt = remaining;
        gap_nxt       = gap_cnt;
        inj_nxt       = inj_q;
        data_nxt      = data_out;
        valid_nxt     = pkt_valid;
        idle_nxt      = idle;
        done_nxt      = 1'b0;
        bad_nxt       = 1'b0;
        pkt_cnt_nxt   = pkt_cnt;

        case (state)
            S_IDLE: begin
                data_nxt  = 8'd0;
                valid_nxt = 1'b0;
                idle_nxt  = 1'b1;
                if (start) begin
                    if (len == 6'd0 || dest == 2'd3) begin
                        bad_nxt = 1'b1;
                    end else begin
                        dest_nxt  = dest;
                        len_nxt   = len;
                        lfsr_nxt  = (seed == 8'd0) ? 8'h01 : seed;
`ifdef ERR_INJECT_EN
                        inj_nxt   = inj_err;
`else
                        inj_nxt   = 1'b0;
`endif
                        data_nxt  = {len, dest};
                        valid_nxt = 1'b1;
                        idle_nxt  = 1'b0;
                        state_nxt = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    parity_nxt    = {len_q, dest_q};
                    remaining_nxt = len_q;
                    data_nxt      = lfsr;
                    state_nxt     = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    parity_nxt    = parity_acc ^ lfsr;
                    remaining_nxt = remaining - 6'd1;
                    lfsr_nxt      = lfsr_step(lfsr);
                    if (remaining == 6'd1) begin
                        data_nxt  = parity_acc ^ lfsr ^ {7'd0, inj_q};
                        valid_nxt = 1'b0;
                        state_nxt = S_PARITY;
                    end else begin
                        data_nxt  = lfsr_step(lfsr);
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    done_nxt    = 1'b1;
                    pkt_cnt_nxt = pkt_cnt + 8'd1;
                    data_nxt    = 8'd0;
                    if (IPG == 0) begin
                        idle_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                data_nxt  = 8'd0;
                valid_nxt = 1'b0;
                if (gap_cnt == 4'd0) begin
                    idle_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                data_nxt  = 8'd0;
                valid_nxt = 1'b0;
                idle_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Router error reports: count rising edges of err, saturating at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q   <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            err_q <= err;
            if (err && !err_q && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// tb/tb_router_pkt_gen.sv - Scoreboard testbench for router_pkt_gen
module tb_router_pkt_gen;

    localparam int IPG = 2;
`ifdef ERR_INJECT_EN
    localparam bit HAS_INJ = 1'b1;
`else
    localparam bit HAS_INJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] seed;
    logic       busy;
    logic       err;
    logic       inj_err;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       idle;
    logic       done;
    logic       bad_req;
    logic [7:0] pkt_cnt;
    logic [7:0] err_cnt;

    router_pkt_gen #(.IPG(IPG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .seed      (seed),
        .busy      (busy),
        .err       (err),
`ifdef ERR_INJECT_EN
        .inj_err   (inj_err),
`endif
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .idle      (idle),
        .done      (done),
        .bad_req   (bad_req),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       done;
        logic       stall;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_bad = 0;
    logic [7:0] exp_pkt = 8'd0;
    int         exp_err = 0;
    bit         mon_en = 1'b0;
    bit         busy_rand = 1'b0;
    bit         err_rand = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_err(input logic v);
        if (v && !err && exp_err < 255) exp_err++;
        err = v;
    endtask

    task automatic push_gap();
        for (int i = 0; i < IPG; i++) sb.push_back('{8'h00, 1'b0, (i == 0), 1'b0});
    endtask

    // Reference packet from the byte-level description: header, payload stream, xor of all
    task automatic push_model(input logic [1:0] d, input logic [5:0] l, input logic [7:0] s, input logic inj);
        logic [7:0] hdr, par, v;
        hdr = {l, d};
        sb.push_back('{hdr, 1'b1, 1'b0, 1'b1});
        par = hdr;
        v = (s == 8'd0) ? 8'h01 : s;
        for (int i = 0; i < l; i++) begin
            sb.push_back('{v, 1'b1, 1'b0, 1'b1});
            par = par ^ v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        sb.push_back('{par ^ {7'd0, inj & HAS_INJ}, 1'b0, 1'b0, 1'b1});
        push_gap();
    endtask

    // Known-answer packet for dest=1, len=3, seed=1
    task automatic push_basic(input logic inj);
        logic [7:0] tbl [5];
        tbl = '{8'h0D, 8'h01, 8'h02, 8'h04, 8'h0A};
        for (int i = 0; i < 4; i++) sb.push_back('{tbl[i], 1'b1, 1'b0, 1'b1});
        sb.push_back('{tbl[4] ^ {7'd0, inj & HAS_INJ}, 1'b0, 1'b0, 1'b1});
        push_gap();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!idle) chk("idle_timeout", idle, 1);
    endtask

    task automatic send(input logic [1:0] d, input logic [5:0] l, input logic [7:0] s,
                        input logic inj, input bit lit, input bit push);
        wait_idle();
        start = 1'b1; dest = d; len = l; seed = s; inj_err = inj;
        if (l == 6'd0 || d == 2'd3) exp_bad++;
        else if (push) begin
            if (lit) push_basic(inj);
            else push_model(d, l, s, inj);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || exp_bad != 0 || !idle) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue", sb.size(), 0);
        chk("drain_bad_req", exp_bad, 0);
    endtask

    // Monitor: compares every presented cycle against the scoreboard head
    always @(negedge clk) begin
        if (rst && mon_en) begin
            if (bad_req) begin
                if (exp_bad > 0) exp_bad--;
                else chk("unexpected_bad_req", bad_req, 0);
                chk("bad_req_with_done", done, 0);
            end
            if (!idle) begin
                if (sb.size() == 0) begin
                    chk("unexpected_activity", idle, 1);
                end else begin
                    chk("data_out", data_out, sb[0].data);
                    chk("pkt_valid", pkt_valid, sb[0].valid);
                    chk("done", done, sb[0].done);
                    if (!busy || !sb[0].stall) begin
                        if (sb[0].done) exp_pkt++;
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_data_out", data_out, 0);
                chk("idle_pkt_valid", pkt_valid, 0);
                chk("idle_done", done, 0);
            end
            chk("pkt_cnt", pkt_cnt, exp_pkt);
        end
    end

    always begin
        @(posedge clk); #1;
        if (busy_rand) busy = ($urandom_range(0, 3) == 0);
        if (err_rand) set_err(logic'($urandom_range(0, 1)));
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; dest = 2'd0; len = 6'd0; seed = 8'd0;
        busy = 1'b0; err = 1'b0; inj_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_done", done, 0);
        chk("rst_bad_req", bad_req, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic packet, then the same packet from a zero seed
        send(2'd1, 6'd3, 8'h01, 1'b0, 1'b1, 1'b1);
        drain();
        send(2'd1, 6'd3, 8'h00, 1'b0, 1'b1, 1'b1);
        drain();
        // Error injection request: parity bit 0 flips only when the feature exists
        send(2'd1, 6'd3, 8'h01, 1'b1, 1'b1, 1'b1);
        drain();

        // Stall for 3 cycles while 0x02 is presented
        send(2'd1, 6'd3, 8'h01, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!(data_out == 8'h02 && pkt_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach_0x02", data_out, 8'h02);
        busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        busy = 1'b0;
        drain();

        // Illegal requests
        send(2'd1, 6'd0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(2'd3, 6'd5, 8'h11, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomized packets with random stalls and router error reports
        busy_rand = 1'b1;
        err_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        busy_rand = 1'b0;
        err_rand = 1'b0;
        busy = 1'b0;
        drain();
        set_err(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("err_cnt_random", err_cnt, exp_err);

        // Reset mid-packet while 0x01 is presented
        mon_en = 1'b0;
        send(2'd1, 6'd3, 8'h01, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(data_out == 8'h01 && pkt_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_reach_0x01", data_out, 8'h01);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_pkt_valid", pkt_valid, 0);
        chk("abort_data_out", data_out, 0);
        chk("abort_idle", idle, 1);
        chk("abort_pkt_cnt", pkt_cnt, 0);
        chk("abort_err_cnt", err_cnt, 0);
        rst = 1'b1;
        exp_pkt = 8'd0;
        exp_err = 0;
        sb.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_resume", idle, 1);

        // err 0->1->0->1 gives two counts, then saturation
        set_err(1'b1); @(posedge clk); #1;
        set_err(1'b0); @(posedge clk); #1;
        set_err(1'b1); @(posedge clk); #1;
        @(posedge clk); #1;
        chk("err_cnt_two", err_cnt, 2);
        for (int i = 0; i < 300; i++) begin
            set_err(1'b0); @(posedge clk); #1;
            set_err(1'b1); @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("err_cnt_saturate", err_cnt, exp_err);
        chk("err_cnt_saturate_abs", err_cnt, 255);
        set_err(1'b0);

        // pkt_cnt wraps after 256 packets
        for (int i = 0; i < 257; i++) begin
            send(2'($urandom_range(0, 2)), 6'd1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
        end
        drain();
        chk("pkt_cnt_wrap", pkt_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
